rf_dump: RTL and testbench

RF_DUMP -- requirements
Module: rf_dump

---
 rtl/rf_dump.sv | 147 ++++++++++++++
 tb/tb_rf_dump.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump.sv
// Register-file dump streamer: walks reg_sel from START_IDX to END_IDX and emits
// 5-byte {index, data} records over a valid/ready byte stream. Optional macro: RF_DUMP_CKSUM_EN.
module rf_dump #(
  parameter int START_IDX = 1,
  parameter int END_IDX   = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

`ifdef RF_DUMP_CKSUM_EN
  typedef enum logic [1:0] {IDLE, CAP, SEND, CKS} state_t;
`else
  typedef enum logic [1:0] {IDLE, CAP, SEND} state_t;
`endif

  localparam logic [4:0] START_SEL = 5'(START_IDX);
  localparam logic [4:0] END_SEL   = 5'(END_IDX);

  state_t      state, state_nxt;
  logic [31:0] hold;
  logic [2:0]  byte_cnt;
  logic        xfer;
  logic        last_byte;
  logic        last_rec;
  logic [7:0]  next_byte;
`ifdef RF_DUMP_CKSUM_EN
  logic [7:0]  cksum;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = CAP;
      CAP:  state_nxt = SEND;
      SEND: begin
        if (xfer && last_byte) begin
          if (!last_rec) state_nxt = CAP;
`ifdef RF_DUMP_CKSUM_EN
          else           state_nxt = CKS;
`else
          else           state_nxt = IDLE;
`endif
        end
      end
`ifdef RF_DUMP_CKSUM_EN
      CKS:  if (xfer) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and record-position decode shared by the datapath.
  always_comb begin
    xfer      = out_valid && out_ready;
    last_byte = (byte_cnt == 3'd4);
    last_rec  = (reg_sel == END_SEL);
    case (byte_cnt)
      3'd0:    next_byte = hold[31:24];
      3'd1:    next_byte = hold[23:16];
      3'd2:    next_byte = hold[15:8];
      3'd3:    next_byte = hold[7:0];
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_sel   <= 5'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hold      <= 32'h0;
      byte_cnt  <= 3'd0;
`ifdef RF_DUMP_CKSUM_EN
      cksum     <= 8'h00;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            reg_sel <= START_SEL;
            busy    <= 1'b1;
`ifdef RF_DUMP_CKSUM_EN
            cksum   <= 8'h00;
`endif
          end
        end
        CAP: begin
          hold      <= reg_data;
          out_data  <= {3'b000, reg_sel};
          out_valid <= 1'b1;
          byte_cnt  <= 3'd0;
        end
        SEND: begin
          if (xfer) begin
`ifdef RF_DUMP_CKSUM_EN
            cksum <= cksum ^ out_data;
`endif
            if (!last_byte) begin
              byte_cnt <= byte_cnt + 3'd1;
              out_data <= next_byte;
            end else if (!last_rec) begin
              reg_sel   <= reg_sel + 5'd1;
              out_valid <= 1'b0;
            end else begin
`ifdef RF_DUMP_CKSUM_EN
              // The checksum byte must also cover the byte leaving on this edge.
              out_data  <= cksum ^ out_data;
`else
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
`endif
            end
          end
        end
`ifdef RF_DUMP_CKSUM_EN
        CKS: begin
          if (xfer) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
// Bench for rf_dump: four instances with different index ranges share one register-file model;
// every dump is compared against a byte list built from the record format.
module tb_rf_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_ready;
  logic        start_v [4];
  logic [4:0]  sel_w   [4];
  logic [7:0]  data_w  [4];
  logic        valid_w [4];
  logic        busy_w  [4];
  logic        done_w  [4];
  logic [31:0] regs    [32];

  logic [1:0]  cur;
  logic [4:0]  m_sel;
  logic [7:0]  m_data;
  logic        m_valid, m_busy, m_done;

  logic [7:0]  got [$];
  logic [7:0]  exp [$];
  int          done_cnt, stall_err, cycles_to_done, busy_after, busy_at_start;
  bit          timeout;
  int          passed = 0;
  int          total  = 0;

  always #5 clk = ~clk;

  rf_dump #(.START_IDX(1), .END_IDX(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .reg_sel(sel_w[0]), .reg_data(regs[sel_w[0]]),
    .out_data(data_w[0]), .out_valid(valid_w[0]), .out_ready(out_ready), .busy(busy_w[0]), .done(done_w[0]));
  rf_dump dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .reg_sel(sel_w[1]), .reg_data(regs[sel_w[1]]),
    .out_data(data_w[1]), .out_valid(valid_w[1]), .out_ready(out_ready), .busy(busy_w[1]), .done(done_w[1]));
  rf_dump #(.START_IDX(5), .END_IDX(5)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .reg_sel(sel_w[2]), .reg_data(regs[sel_w[2]]),
    .out_data(data_w[2]), .out_valid(valid_w[2]), .out_ready(out_ready), .busy(busy_w[2]), .done(done_w[2]));
  rf_dump #(.START_IDX(0), .END_IDX(1)) dut_d (
    .clk(clk), .rst(rst), .start(start_v[3]), .reg_sel(sel_w[3]), .reg_data(regs[sel_w[3]]),
    .out_data(data_w[3]), .out_valid(valid_w[3]), .out_ready(out_ready), .busy(busy_w[3]), .done(done_w[3]));

  always_comb begin
    m_sel   = sel_w[cur];
    m_data  = data_w[cur];
    m_valid = valid_w[cur];
    m_busy  = busy_w[cur];
    m_done  = done_w[cur];
  end

  // Reference stream: index byte then data MSB first per register, optional XOR byte.
  task automatic build_expected(input int s, input int e);
    logic [31:0] w;
    logic [7:0]  x;
    exp.delete();
    x = 8'h00;
    for (int i = s; i <= e; i++) begin
      w = regs[i];
      exp.push_back(8'(i));
      exp.push_back(w[31:24]);
      exp.push_back(w[23:16]);
      exp.push_back(w[15:8]);
      exp.push_back(w[7:0]);
    end
    foreach (exp[k]) x = x ^ exp[k];
`ifdef RF_DUMP_CKSUM_EN
    exp.push_back(x);
`endif
  endtask

  function automatic int expected_cycles(input int nrec);
`ifdef RF_DUMP_CKSUM_EN
    return 6 * nrec + 2;
`else
    return 6 * nrec + 1;
`endif
  endfunction

  // Runs one dump on instance d; mode 0 ready high, 1 ready toggling 1,0,..., 2 random ready.
  task automatic capture(input logic [1:0] d, input int mode, input int restart_at);
    int   cyc;
    int   tail;
    bit   seen_done;
    logic pv, pr;
    logic [7:0] pd;
    cur = d;
    got.delete();
    done_cnt = 0; stall_err = 0; cycles_to_done = 0; timeout = 0; seen_done = 0; tail = 0;
    out_ready = 1'b1;
    start_v[d] = 1'b1;
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    busy_at_start = int'(m_busy);
    busy_after = 0;
    cyc = 1;
    while (tail < 4) begin
      if (cyc > 3000) begin
        timeout = 1;
        break;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start_v[d] = (cyc == restart_at);
      pv = m_valid; pd = m_data; pr = out_ready;
      if (pv && pr) got.push_back(pd);
      @(posedge clk); #1;
      cyc++;
      start_v[d] = 1'b0;
      if (pv && !pr && (!m_valid || m_data !== pd)) stall_err++;
      if (m_done) begin
        done_cnt++;
        if (!seen_done) begin
          cycles_to_done = cyc;
          busy_after = int'(m_busy);
        end
        seen_done = 1;
      end
      if (seen_done) tail++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    cur = 2'd0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (m_sel !== 5'd0)   $display("[TB] FAIL reset_sel got %0d want 0", m_sel);     else passed++;
    total++; if (m_data !== 8'h00) $display("[TB] FAIL reset_data got %02h want 00", m_data); else passed++;
    total++; if (m_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", m_valid);  else passed++;
    total++; if (m_busy !== 1'b0)  $display("[TB] FAIL reset_busy got %b want 0", m_busy);    else passed++;
    total++; if (m_done !== 1'b0)  $display("[TB] FAIL reset_done got %b want 0", m_done);    else passed++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    build_expected(1, 2);
    capture(2'd0, 0, 0);
    total++; if (timeout) $display("[TB] FAIL basic_timeout got 1 want 0"); else passed++;
    total++; if (got.size() != exp.size()) $display("[TB] FAIL basic_count got %0d want %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL basic_byte%0d got %02h want %02h", i, got[i], exp[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("[TB] FAIL basic_done_pulses got %0d want 1", done_cnt); else passed++;
    total++; if (cycles_to_done != expected_cycles(2)) $display("[TB] FAIL basic_cycles got %0d want %0d", cycles_to_done, expected_cycles(2)); else passed++;
    total++; if (busy_at_start != 1) $display("[TB] FAIL basic_busy_start got %0d want 1", busy_at_start); else passed++;
    total++; if (busy_after != 0) $display("[TB] FAIL basic_busy_end got %0d want 0", busy_after); else passed++;
  endtask

  task automatic test_backpressure;
    build_expected(1, 2);
    capture(2'd0, 1, 0);
    total++; if (timeout) $display("[TB] FAIL bp_timeout got 1 want 0"); else passed++;
    total++; if (got.size() != exp.size()) $display("[TB] FAIL bp_count got %0d want %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL bp_byte%0d got %02h want %02h", i, got[i], exp[i]); else passed++;
    end
    total++; if (stall_err != 0) $display("[TB] FAIL bp_stable got %0d changes want 0", stall_err); else passed++;
    total++; if (done_cnt != 1) $display("[TB] FAIL bp_done_pulses got %0d want 1", done_cnt); else passed++;
  endtask

  task automatic test_start_ignored;
    build_expected(1, 2);
    capture(2'd0, 0, 4);
    total++; if (timeout) $display("[TB] FAIL restart_timeout got 1 want 0"); else passed++;
    total++; if (got.size() != exp.size()) $display("[TB] FAIL restart_count got %0d want %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL restart_byte%0d got %02h want %02h", i, got[i], exp[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("[TB] FAIL restart_done_pulses got %0d want 1", done_cnt); else passed++;
    total++; if (m_busy !== 1'b0) $display("[TB] FAIL restart_idle_busy got %b want 0", m_busy); else passed++;
  endtask

  task automatic test_reset_mid;
    int n;
    int cyc;
    int dcount;
    cur = 2'd0;
    out_ready = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 100) begin
      if (m_valid && out_ready) n++;
      @(posedge clk); #1;
      cyc++;
    end
    total++; if (n != 3) $display("[TB] FAIL rstmid_reach got %0d bytes want 3", n); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (m_valid !== 1'b0) $display("[TB] FAIL rstmid_valid got %b want 0", m_valid); else passed++;
    total++; if (m_busy !== 1'b0)  $display("[TB] FAIL rstmid_busy got %b want 0", m_busy);   else passed++;
    total++; if (m_sel !== 5'd0)   $display("[TB] FAIL rstmid_sel got %0d want 0", m_sel);    else passed++;
    dcount = int'(m_done);
    repeat (5) begin
      @(posedge clk); #1;
      dcount += int'(m_done);
    end
    total++; if (dcount != 0) $display("[TB] FAIL rstmid_done got %0d pulses want 0", dcount); else passed++;
    build_expected(1, 2);
    capture(2'd0, 0, 0);
    total++; if (got.size() != exp.size()) $display("[TB] FAIL rstmid_count got %0d want %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL rstmid_byte%0d got %02h want %02h", i, got[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_single_record;
    build_expected(5, 5);
    capture(2'd2, 0, 0);
    total++; if (got.size() != exp.size()) $display("[TB] FAIL single_count got %0d want %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL single_byte%0d got %02h want %02h", i, got[i], exp[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("[TB] FAIL single_done_pulses got %0d want 1", done_cnt); else passed++;
    total++; if (cycles_to_done != expected_cycles(1)) $display("[TB] FAIL single_cycles got %0d want %0d", cycles_to_done, expected_cycles(1)); else passed++;
  endtask

  task automatic test_reg_zero;
    build_expected(0, 1);
    capture(2'd3, 2, 0);
    total++; if (got.size() != exp.size()) $display("[TB] FAIL zero_count got %0d want %0d", got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL zero_byte%0d got %02h want %02h", i, got[i], exp[i]); else passed++;
    end
  endtask

  task automatic test_full_dump(input int mode);
    int li;
    build_expected(1, 31);
    capture(2'd1, mode, 0);
    total++; if (timeout) $display("[TB] FAIL full%0d_timeout got 1 want 0", mode); else passed++;
    total++; if (got.size() != exp.size()) $display("[TB] FAIL full%0d_count got %0d want %0d", mode, got.size(), exp.size()); else passed++;
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      total++; if (got[i] !== exp[i]) $display("[TB] FAIL full%0d_byte%0d got %02h want %02h", mode, i, got[i], exp[i]); else passed++;
    end
    total++; if (done_cnt != 1) $display("[TB] FAIL full%0d_done_pulses got %0d want 1", mode, done_cnt); else passed++;
    total++; if (stall_err != 0) $display("[TB] FAIL full%0d_stable got %0d changes want 0", mode, stall_err); else passed++;
    if (mode == 0) begin
      li = 150;
      total++;
      if (got.size() <= li || got[li] !== 8'h1F) $display("[TB] FAIL full_last_index got %02h want 1f", (got.size() > li) ? got[li] : 8'hxx);
      else passed++;
      total++; if (cycles_to_done != 187 + expected_cycles(31) - expected_cycles(31) + (expected_cycles(1) - 7))
        $display("[TB] FAIL full_cycles got %0d want %0d", cycles_to_done, 187 + expected_cycles(1) - 7);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    cur = 2'd0;
    for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'h0;
    regs[1] = 32'h11223344;
    regs[2] = 32'hAABBCCDD;
    regs[5] = 32'h01020304;

    test_reset;
    test_basic;
    test_backpressure;
    test_start_ignored;
    test_reset_mid;
    test_single_record;
    test_reg_zero;
    test_full_dump(0);
    for (int i = 6; i < 32; i++) regs[i] = $urandom;
    test_full_dump(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
